// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable step, synchronous load, terminal value
// MAX_VAL_P and wrap-or-saturate behaviour, plus a registered wrap/clamp pulse.
module counter_updown_mod #(
  parameter int WIDTH_P    = 8,
  parameter int MAX_VAL_P  = (2**WIDTH_P) - 1,
  parameter bit SATURATE_P = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic [WIDTH_P-1:0] step_i,
  input  logic               load_i,
  input  logic [WIDTH_P-1:0] load_val_i,
  output logic [WIDTH_P-1:0] count_o,
  output logic               wrap_o,
  output logic               at_max_o,
  output logic               at_zero_o
);

  localparam int                 EW_C    = WIDTH_P + 1;
  localparam logic [WIDTH_P:0]   MAX_C   = EW_C'(MAX_VAL_P);
  localparam logic [WIDTH_P:0]   MOD_C   = MAX_C + {{WIDTH_P{1'b0}}, 1'b1};
  localparam logic [WIDTH_P-1:0] MAX_N_C = MAX_C[WIDTH_P-1:0];

  logic [WIDTH_P-1:0] count_q, count_d;
  logic               wrap_q, wrap_d;
  logic [WIDTH_P:0]   count_ext_s, step_ext_s, sum_s, sum_wrap_s, diff_s, diff_wrap_s;

  // Steps beyond one full modulus are limited so at most one wrap happens per edge.
  function automatic logic [WIDTH_P:0] clip_step(input logic [WIDTH_P-1:0] s);
    logic [WIDTH_P:0] e;
    e = {1'b0, s};
    if (e > MOD_C) begin
      clip_step = MOD_C;
    end else begin
      clip_step = e;
    end
  endfunction

  function automatic logic [WIDTH_P-1:0] clamp_load(input logic [WIDTH_P-1:0] v);
    if ({1'b0, v} > MAX_C) begin
      clamp_load = MAX_N_C;
    end else begin
      clamp_load = v;
    end
  endfunction

  // Next-state selection: load > (up & down hold) > up > down > hold.
  always_comb begin
    count_ext_s = {1'b0, count_q};
    step_ext_s  = clip_step(step_i);
    sum_s       = count_ext_s + step_ext_s;
    sum_wrap_s  = sum_s - MOD_C;
    diff_s      = count_ext_s - step_ext_s;
    diff_wrap_s = count_ext_s + MOD_C - step_ext_s;
    count_d     = count_q;
    wrap_d      = 1'b0;
    if (load_i) begin
      count_d = clamp_load(load_val_i);
    end else if (up_i && down_i) begin
      count_d = count_q;
    end else if (up_i) begin
      if (sum_s > MAX_C) begin
        wrap_d = 1'b1;
        if (SATURATE_P) begin
          count_d = MAX_N_C;
        end else begin
          count_d = sum_wrap_s[WIDTH_P-1:0];
        end
      end else begin
        count_d = sum_s[WIDTH_P-1:0];
      end
    end else if (down_i) begin
      if (step_ext_s > count_ext_s) begin
        wrap_d = 1'b1;
        if (SATURATE_P) begin
          count_d = {WIDTH_P{1'b0}};
        end else begin
          count_d = diff_wrap_s[WIDTH_P-1:0];
        end
      end else begin
        count_d = diff_s[WIDTH_P-1:0];
      end
    end else begin
      count_d = count_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= {WIDTH_P{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o   = count_q;
  assign wrap_o    = wrap_q;
  assign at_max_o  = (count_q == MAX_N_C);
  assign at_zero_o = (count_q == {WIDTH_P{1'b0}});

endmodule

// File: tb/tb_counter_updown_mod.sv
// Table-driven bench for counter_updown_mod: three instances (wrap, saturate,
// default 8-bit) with expectations queued on drive and checked after each edge.
module tb_counter_updown_mod;

  typedef struct packed {
    logic [3:0] op;      // {reset, load, up, down}
    logic [7:0] step;
    logic [7:0] lval;
    logic [7:0] e_cnt;
    logic       e_wrap;
  } vec_t;

  typedef struct {
    int         dut;
    int         idx;
    logic [7:0] cnt;
    logic       wrap;
    logic       mx;
    logic       zr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst  [3];
  logic       ld   [3];
  logic       up   [3];
  logic       dn   [3];
  logic [7:0] step [3];
  logic [7:0] lval [3];

  logic [3:0] cnt_a, cnt_b;
  logic [7:0] cnt_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       max_a, max_b, max_c;
  logic       zero_a, zero_b, zero_c;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tab[$];
  exp_t sb[$];
  logic [7:0] maxv [3] = '{8'd9, 8'd9, 8'd255};

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH_P(4), .MAX_VAL_P(9), .SATURATE_P(1'b0)) dut_a (
    .clk_i(clk), .reset_i(rst[0]), .up_i(up[0]), .down_i(dn[0]),
    .step_i(step[0][3:0]), .load_i(ld[0]), .load_val_i(lval[0][3:0]),
    .count_o(cnt_a), .wrap_o(wrap_a), .at_max_o(max_a), .at_zero_o(zero_a));

  counter_updown_mod #(.WIDTH_P(4), .MAX_VAL_P(9), .SATURATE_P(1'b1)) dut_b (
    .clk_i(clk), .reset_i(rst[1]), .up_i(up[1]), .down_i(dn[1]),
    .step_i(step[1][3:0]), .load_i(ld[1]), .load_val_i(lval[1][3:0]),
    .count_o(cnt_b), .wrap_o(wrap_b), .at_max_o(max_b), .at_zero_o(zero_b));

  counter_updown_mod dut_c (
    .clk_i(clk), .reset_i(rst[2]), .up_i(up[2]), .down_i(dn[2]),
    .step_i(step[2]), .load_i(ld[2]), .load_val_i(lval[2]),
    .count_o(cnt_c), .wrap_o(wrap_c), .at_max_o(max_c), .at_zero_o(zero_c));

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] st,
                              input logic [7:0] lv, input logic [7:0] ec,
                              input logic ew);
    vec_t v;
    v.op = op; v.step = st; v.lval = lv; v.e_cnt = ec; v.e_wrap = ew;
    return v;
  endfunction

  task automatic cmp(input string name, input int d, input int idx,
                     input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d vec%0d: got %0d, expected %0d", name, d, idx, act, req);
    end
  endtask

  task automatic check_front();
    exp_t       e;
    logic [7:0] a_cnt;
    logic       a_wrap, a_max, a_zero;
    e = sb.pop_front();
    case (e.dut)
      0:       begin a_cnt = {4'd0, cnt_a}; a_wrap = wrap_a; a_max = max_a; a_zero = zero_a; end
      1:       begin a_cnt = {4'd0, cnt_b}; a_wrap = wrap_b; a_max = max_b; a_zero = zero_b; end
      default: begin a_cnt = cnt_c;         a_wrap = wrap_c; a_max = max_c; a_zero = zero_c; end
    endcase
    cmp("count",   e.dut, e.idx, a_cnt,          e.cnt);
    cmp("wrap",    e.dut, e.idx, {7'd0, a_wrap}, {7'd0, e.wrap});
    cmp("at_max",  e.dut, e.idx, {7'd0, a_max},  {7'd0, e.mx});
    cmp("at_zero", e.dut, e.idx, {7'd0, a_zero}, {7'd0, e.zr});
  endtask

  task automatic run_tab(input int d);
    exp_t e;
    for (int i = 0; i < tab.size(); i++) begin
      {rst[d], ld[d], up[d], dn[d]} = tab[i].op;
      step[d] = tab[i].step;
      lval[d] = tab[i].lval;
      e.dut = d; e.idx = i; e.cnt = tab[i].e_cnt; e.wrap = tab[i].e_wrap;
      e.mx = (tab[i].e_cnt == maxv[d]);
      e.zr = (tab[i].e_cnt == 8'd0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_front();
    end
    {rst[d], ld[d], up[d], dn[d]} = 4'b0000;
    step[d] = 8'd0;
    lval[d] = 8'd0;
    tab.delete();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; ld[d] = 1'b0; up[d] = 1'b0; dn[d] = 1'b0;
      step[d] = 8'd0; lval[d] = 8'd0;
    end
    @(posedge clk);
    #1;

    // Modulo-10 wrap counter
    tab.push_back(mk(4'b1000, 8'd0, 8'd0, 8'd0, 1'b0));
    for (int i = 1; i <= 12; i++) tab.push_back(mk(4'b0010, 8'd1, 8'd0, 8'(i % 10), (i == 10)));
    tab.push_back(mk(4'b0100, 8'd0,  8'd7,  8'd7, 1'b0));
    tab.push_back(mk(4'b0010, 8'd5,  8'd0,  8'd2, 1'b1));
    tab.push_back(mk(4'b0001, 8'd3,  8'd0,  8'd9, 1'b1));
    tab.push_back(mk(4'b0001, 8'd9,  8'd0,  8'd0, 1'b0));
    tab.push_back(mk(4'b0110, 8'd1,  8'd3,  8'd3, 1'b0));
    tab.push_back(mk(4'b0011, 8'd1,  8'd0,  8'd3, 1'b0));
    tab.push_back(mk(4'b0100, 8'd0,  8'd15, 8'd9, 1'b0));
    tab.push_back(mk(4'b0010, 8'd1,  8'd0,  8'd0, 1'b1));
    tab.push_back(mk(4'b0001, 8'd1,  8'd0,  8'd9, 1'b1));
    tab.push_back(mk(4'b0010, 8'd0,  8'd0,  8'd9, 1'b0));
    tab.push_back(mk(4'b0001, 8'd10, 8'd0,  8'd9, 1'b1));
    tab.push_back(mk(4'b0010, 8'd15, 8'd0,  8'd9, 1'b1));
    tab.push_back(mk(4'b0001, 8'd4,  8'd0,  8'd5, 1'b0));
    tab.push_back(mk(4'b0010, 8'd4,  8'd0,  8'd9, 1'b0));
    tab.push_back(mk(4'b0010, 8'd1,  8'd0,  8'd0, 1'b1));
    tab.push_back(mk(4'b1000, 8'd0,  8'd0,  8'd0, 1'b0));
    tab.push_back(mk(4'b0001, 8'd1,  8'd0,  8'd9, 1'b1));
    tab.push_back(mk(4'b0100, 8'd0,  8'd6,  8'd6, 1'b0));
    tab.push_back(mk(4'b1010, 8'd1,  8'd0,  8'd0, 1'b0));
    tab.push_back(mk(4'b0010, 8'd1,  8'd0,  8'd1, 1'b0));
    tab.push_back(mk(4'b0010, 8'd1,  8'd0,  8'd2, 1'b0));
    tab.push_back(mk(4'b0000, 8'd3,  8'd0,  8'd2, 1'b0));
    run_tab(0);

    // Saturating counter, 0..9
    tab.push_back(mk(4'b1000, 8'd0,  8'd0,  8'd0, 1'b0));
    tab.push_back(mk(4'b0100, 8'd0,  8'd8,  8'd8, 1'b0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(4'b0010, 8'd4, 8'd0, 8'd9, 1'b1));
    tab.push_back(mk(4'b0001, 8'd12, 8'd0,  8'd0, 1'b1));
    tab.push_back(mk(4'b0001, 8'd1,  8'd0,  8'd0, 1'b1));
    tab.push_back(mk(4'b0001, 8'd0,  8'd0,  8'd0, 1'b0));
    tab.push_back(mk(4'b0010, 8'd3,  8'd0,  8'd3, 1'b0));
    tab.push_back(mk(4'b0010, 8'd6,  8'd0,  8'd9, 1'b0));
    tab.push_back(mk(4'b0001, 8'd9,  8'd0,  8'd0, 1'b0));
    tab.push_back(mk(4'b0100, 8'd0,  8'd15, 8'd9, 1'b0));
    tab.push_back(mk(4'b0011, 8'd1,  8'd0,  8'd9, 1'b0));
    tab.push_back(mk(4'b0010, 8'd1,  8'd0,  8'd9, 1'b1));
    tab.push_back(mk(4'b0001, 8'd3,  8'd0,  8'd6, 1'b0));
    tab.push_back(mk(4'b0010, 8'd15, 8'd0,  8'd9, 1'b1));
    run_tab(1);

    // Default 8-bit modulo-256 counter
    tab.push_back(mk(4'b1000, 8'd0,   8'd0,   8'd0,   1'b0));
    tab.push_back(mk(4'b0100, 8'd0,   8'd254, 8'd254, 1'b0));
    tab.push_back(mk(4'b0010, 8'd2,   8'd0,   8'd0,   1'b1));
    tab.push_back(mk(4'b0010, 8'd0,   8'd0,   8'd0,   1'b0));
    tab.push_back(mk(4'b0100, 8'd0,   8'd255, 8'd255, 1'b0));
    tab.push_back(mk(4'b0010, 8'd1,   8'd0,   8'd0,   1'b1));
    tab.push_back(mk(4'b0001, 8'd1,   8'd0,   8'd255, 1'b1));
    tab.push_back(mk(4'b0001, 8'd255, 8'd0,   8'd0,   1'b0));
    tab.push_back(mk(4'b0010, 8'd255, 8'd0,   8'd255, 1'b0));
    tab.push_back(mk(4'b0010, 8'd200, 8'd0,   8'd199, 1'b1));
    tab.push_back(mk(4'b0001, 8'd200, 8'd0,   8'd255, 1'b1));
    tab.push_back(mk(4'b0000, 8'd7,   8'd0,   8'd255, 1'b0));
    run_tab(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
